// File: rtl/aes128_round_core.sv
//==============================================================================
// Module   : aes128_round_core
// Brief    : Iterative AES-128 encryption datapath, one cipher round per clock.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes128_round_core #(
    parameter int ROUNDS = 10,
    parameter int KEYS_W = 1408
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:KEYS_W-1] keys,
    input  logic              keys_valid,
    input  logic [0:127]      in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [0:127]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e       fsm_q, fsm_d;
    logic [0:127] state_q, state_d;
    logic [0:127] out_data_q, out_data_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [0:127] round_keys [0:ROUNDS];
    logic [0:127] sub_bytes;
    logic [0:127] shift_rows;
    logic [0:127] mix_cols;
    logic [0:127] rk_sel;
    logic [0:127] round_out;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{x, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    generate
        for (genvar i = 0; i <= ROUNDS; i++) begin : g_rk
            assign round_keys[i] = keys[128*i +: 128];
        end

        for (genvar i = 0; i < 16; i++) begin : g_sbox
            assign sub_bytes[8*i +: 8] = sbox(state_q[8*i +: 8]);
        end

        // Byte 4c+r is row r, column c; row r rotates left by r columns.
        for (genvar c = 0; c < 4; c++) begin : g_shift_col
            for (genvar r = 0; r < 4; r++) begin : g_shift_row
                assign shift_rows[8*(4*c+r) +: 8] = sub_bytes[8*(4*((c+r)%4)+r) +: 8];
            end
        end

        for (genvar c = 0; c < 4; c++) begin : g_mix
            logic [7:0] b0, b1, b2, b3;
            assign b0 = shift_rows[8*(4*c)   +: 8];
            assign b1 = shift_rows[8*(4*c+1) +: 8];
            assign b2 = shift_rows[8*(4*c+2) +: 8];
            assign b3 = shift_rows[8*(4*c+3) +: 8];
            assign mix_cols[8*(4*c)   +: 8] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
            assign mix_cols[8*(4*c+1) +: 8] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
            assign mix_cols[8*(4*c+2) +: 8] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
            assign mix_cols[8*(4*c+3) +: 8] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
        end
    endgenerate

    always_comb begin
        rk_sel = '0;
        for (int i = 1; i <= ROUNDS; i++) begin
            if (rnd_q == 4'(i)) begin
                rk_sel = round_keys[i];
            end
        end
    end

    assign round_out = ((rnd_q == LAST_RND) ? shift_rows : mix_cols) ^ rk_sel;

    // Gated by reset so no block can be offered while the core is held in reset.
    assign in_ready  = (fsm_q == ST_IDLE) && keys_valid && reset;
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q != ST_IDLE);
    assign out_data  = out_data_q;

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        out_data_d = out_data_q;
        rnd_d      = rnd_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = in_data ^ round_keys[0];
                    rnd_d   = 4'd1;
                    fsm_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = round_out;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == LAST_RND) begin
                    out_data_d = round_out;
                    rnd_d      = 4'd0;
                    fsm_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q      <= ST_IDLE;
            state_q    <= '0;
            out_data_q <= '0;
            rnd_q      <= 4'd0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            rnd_q      <= rnd_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes128_round_core.sv
//==============================================================================
// Module   : tb_aes128_round_core
// Brief    : Directed-vector self-checking bench for aes128_round_core.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_aes128_round_core;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] R1_B   = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        bit           chk_r1;
        logic [127:0] r1;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [0:1407] keys;
    logic          keys_valid;
    logic [0:127]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [0:127]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int n_vec  = 0;
    int n_miss = 0;

    aes128_round_core dut (
        .clk        (clk),
        .reset      (reset),
        .keys       (keys),
        .keys_valid (keys_valid),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // FIPS-197 KeyExpansion, packed with round key i at bits 128*i.
    function automatic logic [0:1407] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [0:1407] r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [3];
        int   lat;

        vecs[0] = '{key: KEY_C1,  pt: PT_C1,  ct: CT_C1, chk_r1: 1'b0, r1: '0};
        vecs[1] = '{key: KEY_B,   pt: PT_B,   ct: CT_B,  chk_r1: 1'b1, r1: R1_B};
        vecs[2] = '{key: 128'h0,  pt: 128'h0, ct: CT_Z,  chk_r1: 1'b0, r1: '0};

        reset      = 1'b0;
        keys       = expand(KEY_C1);
        keys_valid = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;

        #12;
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_out_data",  out_data,  0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 1);

        // Table-driven single blocks with a ready consumer.
        for (int i = 0; i < 3; i++) begin
            keys     = expand(vecs[i].key);
            in_data  = vecs[i].pt;
            in_valid = 1'b1;
            check($sformatf("v%0d_in_ready", i), in_ready, 1);
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_busy", i), busy, 1);
            lat = 0;
            while (!out_valid && lat < 40) begin
                tick();
                lat++;
                if (lat == 1 && vecs[i].chk_r1)
                    check($sformatf("v%0d_round1", i), dut.state_q, vecs[i].r1);
            end
            check($sformatf("v%0d_latency", i), lat, 10);
            check($sformatf("v%0d_ct", i), out_data, vecs[i].ct);
            tick();
            check($sformatf("v%0d_valid_drop", i), out_valid, 0);
            check($sformatf("v%0d_ready_back", i), in_ready, 1);
        end

        // Output stall: all-zero block held for 20 cycles.
        keys      = expand(128'h0);
        in_data   = '0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("stall_latency", lat, 10);
        check("stall_ct", out_data, CT_Z);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_data",  out_data,  CT_Z);
            check("stall_ready", in_ready,  0);
        end
        out_ready = 1'b1;
        tick();
        check("stall_release_valid", out_valid, 0);
        check("stall_release_ready", in_ready,  1);

        // Back-to-back with in_valid held high; in_data changes during ROUND.
        keys     = expand(KEY_C1);
        in_data  = PT_C1;
        in_valid = 1'b1;
        check("b2b_ready0", in_ready, 1);
        tick();
        in_data = PT_B;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c < 10) check($sformatf("b2b_novalid_c%0d", c), out_valid, 0);
            if (c == 10) begin
                check("b2b_valid1", out_valid, 1);
                check("b2b_ct1", out_data, CT_C1);
                keys = expand(KEY_B);
            end
            if (c <= 10) check($sformatf("b2b_noready_c%0d", c), in_ready, 0);
            if (c == 11) check("b2b_ready_c11", in_ready, 1);
        end
        tick();
        in_valid = 1'b0;
        check("b2b_busy2", busy, 1);
        wait_out(lat);
        check("b2b_latency2", lat, 10);
        check("b2b_ct2", out_data, CT_B);
        tick();

        // Asynchronous reset in the middle of round 5.
        keys     = expand(KEY_C1);
        in_data  = PT_C1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid",    out_valid, 0);
        check("mid_rst_busy",     busy,      0);
        check("mid_rst_out_data", out_data,  0);
        check("mid_rst_in_ready", in_ready,  0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("mid_dropped_valid", out_valid, 0);
        end
        keys     = expand(KEY_B);
        in_data  = PT_B;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check("post_rst_latency", lat, 10);
        check("post_rst_ct", out_data, CT_B);
        tick();

        // keys_valid gating of acceptance.
        keys_valid = 1'b0;
        keys       = expand(128'h0);
        in_data    = '0;
        in_valid   = 1'b1;
        #1;
        check("kv_low_ready", in_ready, 0);
        tick();
        tick();
        check("kv_low_busy", busy, 0);
        keys_valid = 1'b1;
        #1;
        check("kv_high_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("kv_accept_busy", busy, 1);
        wait_out(lat);
        check("kv_latency", lat, 10);
        check("kv_ct", out_data, CT_Z);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
